// File: rtl/bfc_pkg.sv
// Shared types, default geometry and output clamp for the binary-weight FC layer.
// Purely declarative: no latency, no backpressure.
package bfc_pkg;

    localparam int DEF_LANES   = 6;
    localparam int DEF_DW      = 32;
    localparam int DEF_BEATS   = 32;
    localparam int DEF_NEURONS = 10;
    localparam int DEF_ACC_W   = DEF_DW + $clog2(DEF_LANES * DEF_BEATS) + 1;
    localparam int WBITS       = DEF_NEURONS * DEF_BEATS * DEF_LANES;

    // Clamp is evaluated at a fixed wide width so any DW/ACC_W up to 64 bits fits.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic signed [SAT_W-1:0] sat_dw(input logic signed [SAT_W-1:0] acc,
                                                       input int dw);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = ~hi;
        if (acc > hi)
            sat_dw = hi;
        else if (acc < lo)
            sat_dw = lo;
        else
            sat_dw = acc;
    endfunction

endpackage

// File: rtl/bfc_layer_if.sv
// Input beat stream and per-neuron result stream of bfc_layer, both valid/ready.
// master = upstream producer / downstream consumer side, slave = the layer.
interface bfc_layer_if #(
    parameter int LANES   = 6,
    parameter int DW      = 32,
    parameter int NEURONS = 10
);
    localparam int IDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DW-1:0]     din;
    logic                    o_valid;
    logic                    o_ready;
    logic signed [DW-1:0]    o_data;
    logic [IDX_W-1:0]        o_idx;
    logic                    o_last;

    modport master (
        output in_valid, din, o_ready,
        input  in_ready, o_valid, o_data, o_idx, o_last
    );

    modport slave (
        input  in_valid, din, o_ready,
        output in_ready, o_valid, o_data, o_idx, o_last
    );

endinterface

// File: rtl/bfc_lane_sum.sv
// Combinational signed sum of +/-din over LANES lanes (weight 1 = +din, 0 = -din).
// Zero latency, no flow control.
module bfc_lane_sum #(
    parameter int LANES = 6,
    parameter int DW    = 32,
    parameter int ACC_W = 41
) (
    input  logic [LANES*DW-1:0]     din,
    input  logic [LANES-1:0]        w,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0] term;

    always_comb begin
        sum  = '0;
        term = '0;
        for (int l = 0; l < LANES; l++) begin
            term = ACC_W'(signed'(din[l*DW +: DW]));
            sum  = w[l] ? (sum + term) : (sum - term);
        end
    end

endmodule

// File: rtl/bfc_layer.sv
// Binary-weight FC layer: serial weight load, LANES-wide beat accumulation, per-neuron drain.
// Results 1 cycle after the last beat; in_ready drops while loading/draining, drain holds under o_ready=0.
module bfc_layer
    import bfc_pkg::*;
#(
    parameter int LANES   = DEF_LANES,
    parameter int DW      = DEF_DW,
    parameter int BEATS   = DEF_BEATS,
    parameter int NEURONS = DEF_NEURONS,
    parameter int ACC_W   = DW + $clog2(LANES * BEATS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             weight,
    input  logic             weight_en,
    input  logic             reload,
    input  logic             bin_mode,
    output logic             wt_err,
    bfc_layer_if.slave       bus
);

    localparam int WMEM_BITS = NEURONS * BEATS * LANES;
    localparam int WCNT_W    = $clog2(WMEM_BITS);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W     = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    state_t                  state;
    logic [WMEM_BITS-1:0]    wmem;
    logic [WCNT_W-1:0]       wcnt;
    logic [BEAT_W-1:0]       beat;
    logic [IDX_W-1:0]        idx;
    logic                    reload_pend;
    logic signed [ACC_W-1:0] acc      [NEURONS];
    logic signed [ACC_W-1:0] lane_sum [NEURONS];
    logic [LANES-1:0]        wbeat    [NEURONS][BEATS];
    logic signed [ACC_W-1:0] acc_sel;
    logic                    take_reload;
    logic                    beat_acc;
    logic                    out_hs;

    // A reload request only takes effect at a frame boundary, never mid-vector.
    assign take_reload  = (state == ACC) && (beat == '0) && (reload_pend || reload);
    assign bus.in_ready = (state == ACC) && !take_reload;
    assign beat_acc     = bus.in_valid && bus.in_ready;
    assign bus.o_valid  = (state == DRAIN);
    assign out_hs       = bus.o_valid && bus.o_ready;

    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        for (genvar b = 0; b < BEATS; b++) begin : g_beat
            assign wbeat[n][b] = wmem[(n*BEATS + b)*LANES +: LANES];
        end

        bfc_lane_sum #(
            .LANES (LANES),
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane_sum (
            .din (bus.din),
            .w   (wbeat[n][beat]),
            .sum (lane_sum[n])
        );
    end

    always_comb begin
        acc_sel    = acc[idx];
        bus.o_data = '0;
        if (state == DRAIN) begin
            if (bin_mode)
                bus.o_data = acc_sel[ACC_W-1] ? '1 : DW'(1);
            else
                bus.o_data = DW'(sat_dw(SAT_W'(acc_sel), DW));
        end
    end

    assign bus.o_idx  = idx;
    assign bus.o_last = (state == DRAIN) && (idx == IDX_W'(NEURONS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            wcnt        <= '0;
            beat        <= '0;
            idx         <= '0;
            reload_pend <= 1'b0;
            wt_err      <= 1'b0;
            for (int n = 0; n < NEURONS; n++)
                acc[n] <= '0;
        end else begin
            if (weight_en && (state != LOAD))
                wt_err <= 1'b1;

            if (take_reload)
                reload_pend <= 1'b0;
            else if (reload)
                reload_pend <= 1'b1;

            case (state)
                LOAD: begin
                    if (weight_en) begin
                        wmem[wcnt] <= weight;
                        if (wcnt == WCNT_W'(WMEM_BITS - 1)) begin
                            wcnt  <= '0;
                            beat  <= '0;
                            state <= ACC;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (take_reload) begin
                        wcnt  <= '0;
                        state <= LOAD;
                    end else if (beat_acc) begin
                        // Beat 0 restarts the sums, so no explicit clear between frames.
                        for (int n = 0; n < NEURONS; n++)
                            acc[n] <= ((beat == '0) ? '0 : acc[n]) + lane_sum[n];
                        if (beat == BEAT_W'(BEATS - 1)) begin
                            beat  <= '0;
                            idx   <= '0;
                            state <= DRAIN;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (idx == IDX_W'(NEURONS - 1)) begin
                            idx   <= '0;
                            beat  <= '0;
                            state <= ACC;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/bfc_layer.md
# bfc_layer

Parametrised binary-weight fully-connected layer; successor to the single-neuron `fc` block. It streams an input feature vector of LANES×BEATS signed words and computes NEURONS dot products against a serially loaded ±1 weight memory. Results are returned one neuron at a time over a ready/valid output, as either saturated sums or binarised ±1. It sits after the last conv/pool stage and feeds the classifier argmax.

## Interface
- LANES, 6, input words per beat
- DW, 32, input/output word width (signed)
- BEATS, 32, beats per input vector (vector length LANES×BEATS)
- NEURONS, 10, output neurons
- ACC_W, DW+$clog2(LANES*BEATS)+1, accumulator width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- weight  in  1  serial weight bit: 1 = +1, 0 = −1
- weight_en  in  1  weight bit valid
- reload  in  1  pulse: request a new weight load
- bin_mode  in  1  1 = output sign (±1), 0 = saturated sum; sampled per output word
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- din  in  LANES*DW  lane l at bits [l*DW +: DW], signed
- o_valid  out  1  result valid
- o_ready  in  1  result consumed when o_valid & o_ready
- o_data  out  DW  signed result
- o_idx  out  $clog2(NEURONS)  neuron index of o_data
- o_last  out  1  high with neuron NEURONS−1
- wt_err  out  1  sticky: weight_en seen outside LOAD

## Operation
- States: LOAD, ACC, DRAIN. Reset → LOAD; all counters 0; all outputs 0.
- LOAD: each weight_en cycle stores weight at bit index k = wcnt. Index order: k = ((n·BEATS)+b)·LANES + l. When the bit at k = NEURONS·BEATS·LANES−1 is stored → ACC, beat = 0. in_ready = 0.
- ACC: in_ready = 1. On each accepted beat b:
  - each neuron n does acc[n] ← (b==0 ? 0 : acc[n]) + Σ_l (w[n][b][l] ? +din_l : −din_l);
  - all neurons update in parallel.
  - After beat BEATS−1 is accepted → DRAIN, idx = 0.
- DRAIN: o_valid = 1, in_ready = 0.
  - bin_mode=1: o_data = acc[idx] ≥ 0 ? +1 : −1.
  - bin_mode=0: o_data = acc[idx] clamped to [−2^(DW−1), 2^(DW−1)−1].
  - Each handshake increments idx. The handshake at idx = NEURONS−1 → ACC, beat = 0.
- reload: honoured only in ACC with beat = 0 → LOAD, wcnt = 0. At any other time, reload is held pending and taken at the next such point.
- weight_en outside LOAD: ignored; sets wt_err (cleared only by rst).
- Arithmetic: sign-extend to ACC_W before summing; ACC_W is sized so no overflow is possible. Saturation applies only at the output.

## Timing
- Accumulators update on the same edge that accepts the beat.
- o_valid rises the cycle after the last beat is accepted.
- Frame latency (last beat accepted → first o_valid) = 1 cycle.
- Minimum frame period = BEATS + NEURONS cycles. in_valid may stay high continuously; the stall comes from in_ready.
- DRAIN under stall (o_ready = 0): o_data, o_idx and o_last are held stable. bin_mode must be held stable while o_valid = 1.
- ACC is first entered the cycle after the final weight bit; in_ready is high in that cycle.
- rst mid-frame or mid-load: immediate return to LOAD. Weights are invalid and must be fully reloaded. Partial accumulators are discarded.
- o_ready and in_valid are ignored in states where the corresponding valid/ready is low.

## Structure
- Package bfc_pkg:
  - state enum {LOAD, ACC, DRAIN};
  - function sat_dw(acc) for the output clamp;
  - localparam WBITS = NEURONS·BEATS·LANES.
- Sub-module bfc_lane_sum (params LANES, DW, ACC_W): inputs LANES·DW data and LANES weight bits; output combinational signed ACC_W sum of ±din. Instantiated NEURONS times.
- Weight memory is a flat WBITS register vector, written bit-serially. Beat b's slice is selected by beat counter.

## Test plan
- Default params, load 1920 ones, stream 32 beats with every lane = 1 → 10 outputs each 192, o_idx 0..9, o_last on idx 9. With bin_mode = 1 → all +1.
- Neuron 3 weights all 0, others all 1; all lanes = −5 → neuron 3 = +960, others = −960. o_ready toggled 1/0 shows data held while stalled.
- All weights 1, all lanes = 0x7FFFFFFF, bin_mode = 0 → each output saturates to 0x7FFFFFFF. Same test with 0x80000000 → 0x80000000.
- Back-to-back frames with in_valid held high → in_ready low for exactly 10 cycles between frames. Second frame results are independent of the first (accumulator cleared at beat 0).
- weight_en pulsed during ACC → wt_err = 1, results unchanged. reload during DRAIN → LOAD entered only after idx 9 handshake. New weights (all 0) with lanes = 1 → −192.
- rst asserted at beat 15 → outputs 0, state LOAD, in_ready = 0. After full reload, a clean frame gives correct sums.
